// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exception flag layout, default widths and the
// result record carried between the datapaths and the result stage.
package fpu_pkg;

  localparam int FLAG_W     = 5;
  localparam int FPU_DATA_W = 32;
  localparam int FPU_TAG_W  = 5;

  // Bit positions inside the exception vector {NV, DZ, OF, UF, NX}.
  localparam int NX = 0;
  localparam int UF = 1;
  localparam int OF = 2;
  localparam int DZ = 3;
  localparam int NV = 4;

  typedef struct packed {
    logic [FPU_DATA_W-1:0] result;
    logic [FPU_TAG_W-1:0]  tag;
    logic [FLAG_W-1:0]     flags;
  } fpu_result_t;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } count_e;

endpackage

// File: rtl/fflags_acc.sv
// Sticky accrued-exception register: software writes and committed result
// flags merge so a commit in the same cycle as a write is never lost.
module fflags_acc #(
  parameter int FLAG_W = fpu_pkg::FLAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [FLAG_W-1:0] wr_data,
  input  logic              commit,
  input  logic [FLAG_W-1:0] commit_flags,
  output logic [FLAG_W-1:0] fflags
);

  logic [FLAG_W-1:0] base;
  logic [FLAG_W-1:0] fflags_d;

  // NOTE: combinational blocks assign every output a default first, so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    base     = wr_en ? wr_data : fflags;
    fflags_d = base;
    if (commit) fflags_d = base | commit_flags;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) fflags <= '0;
    else     fflags <= fflags_d;
  end

endmodule

// File: rtl/fpu_result_stage.sv
// Two-entry in-order skid buffer for FPU results with valid/ready on both
// sides; committed results accrue their exceptions into fflags.
module fpu_result_stage
  import fpu_pkg::*;
#(
  parameter int DATA_W = FPU_DATA_W,
  parameter int TAG_W  = FPU_TAG_W,
  parameter int FLAG_W = fpu_pkg::FLAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic [FLAG_W-1:0] fflags,
  input  logic              csr_wr_en,
  input  logic [FLAG_W-1:0] csr_wr_data,
  output logic              busy
);

  count_e      state_q, state_d;
  logic        head_q;
  logic        tail;
  logic        accept;
  logic        commit;
  fpu_result_t entry_q [2];
  fpu_result_t head_entry;

  // Ready comes from registered occupancy only; rst forces it low so nothing
  // is taken while the buffer is being cleared.
  assign in_ready   = !rst && (state_q != CNT_FULL);
  assign out_valid  = (state_q != CNT_EMPTY);
  assign busy       = out_valid;
  assign accept     = in_valid && in_ready;
  assign commit     = out_valid && out_ready;

  // With one entry held the free slot is the one after head.
  assign tail       = head_q ^ (state_q == CNT_ONE);
  assign head_entry = entry_q[head_q];
  assign out_result = head_entry.result;
  assign out_tag    = head_entry.tag;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CNT_EMPTY: if (accept) state_d = CNT_ONE;
      CNT_ONE: begin
        if (accept && !commit)      state_d = CNT_FULL;
        else if (commit && !accept) state_d = CNT_EMPTY;
      end
      CNT_FULL:  if (commit) state_d = CNT_ONE;
      default:   state_d = CNT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CNT_EMPTY;
      head_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (commit) head_q <= ~head_q;
    end
  end

  // NOTE: the two storage entries are cleared on reset so the outputs read
  // zero while empty; larger memories would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else if (accept) begin
      entry_q[tail] <= '{result: in_result, tag: in_tag, flags: in_flags};
    end
  end

  fflags_acc #(
    .FLAG_W (FLAG_W)
  ) u_fflags_acc (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (csr_wr_en),
    .wr_data      (csr_wr_data),
    .commit       (commit),
    .commit_flags (head_entry.flags),
    .fflags       (fflags)
  );

endmodule

// File: tb/tb_fpu_result_stage.sv
// Directed self-checking bench for fpu_result_stage: reset, latency, skid
// behaviour, stall stability, fflags merge rules and streaming throughput.
module tb_fpu_result_stage;

  localparam logic [4:0] F_NX = 5'(1 << fpu_pkg::NX);
  localparam logic [4:0] F_UF = 5'(1 << fpu_pkg::UF);
  localparam logic [4:0] F_NV = 5'(1 << fpu_pkg::NV);

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_tag;
  logic [4:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic [4:0]  fflags;
  logic        csr_wr_en;
  logic [4:0]  csr_wr_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpu_result_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_tag      (in_tag),
    .in_flags    (in_flags),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .fflags      (fflags),
    .csr_wr_en   (csr_wr_en),
    .csr_wr_data (csr_wr_data),
    .busy        (busy)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] t,
                       input logic [4:0] f);
    in_valid  = v;
    in_result = r;
    in_tag    = t;
    in_flags  = f;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; csr_wr_en = 1'b0; csr_wr_data = '0;
    drive(1'b0, '0, '0, '0);
    tick(); tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (out_result !== 32'h0 || out_tag !== 5'h0) begin n_fail++; $display("FAIL reset_outputs: got %h/%h want 0/0", out_result, out_tag); end
    n_checks++; if (fflags !== 5'h00) begin n_fail++; $display("FAIL reset_fflags: got %h want 00", fflags); end
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 32'h3F800000, 5'd3, 5'h00);
    tick();
    drive(1'b0, '0, '0, '0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: out_valid got %b want 1", out_valid); end
    n_checks++; if (out_result !== 32'h3F800000) begin n_fail++; $display("FAIL single_result: got %h want 3f800000", out_result); end
    n_checks++; if (out_tag !== 5'd3) begin n_fail++; $display("FAIL single_tag: got %0d want 3", out_tag); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: out_valid got %b want 0", out_valid); end
    n_checks++; if (fflags !== 5'h00) begin n_fail++; $display("FAIL single_fflags: got %h want 00", fflags); end
  endtask

  // Fill with out_ready low, stall while FULL, then drain in order.
  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 32'h4B800000, 5'd1, 5'h00);
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_one: got %b want 1", in_ready); end
    drive(1'b1, 32'h4F800000, 5'd2, F_NX);
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b want 0", in_ready); end
    n_checks++; if (fflags !== 5'h00) begin n_fail++; $display("FAIL b2b_uncommitted_flags: got %h want 00", fflags); end
    drive(1'b1, 32'hCF000000, 5'd3, 5'h00);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_result !== 32'h4B800000 || out_tag !== 5'd1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_cycle%0d: result %h tag %0d ready %b valid %b want 4b800000 1 0 1", i, out_result, out_tag, in_ready, out_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_result !== 32'h4F800000 || out_tag !== 5'd2) begin n_fail++; $display("FAIL drain_second: got %h/%0d want 4f800000/2", out_result, out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_space_freed: in_ready got %b want 1", in_ready); end
    n_checks++; if (fflags !== 5'h00) begin n_fail++; $display("FAIL drain_fflags_first: got %h want 00", fflags); end
    tick();
    drive(1'b0, '0, '0, '0);
    n_checks++; if (out_result !== 32'hCF000000 || out_tag !== 5'd3 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL drain_third: got %h/%0d valid %b want cf000000/3 1", out_result, out_tag, out_valid);
    end
    n_checks++; if (fflags !== 5'h01) begin n_fail++; $display("FAIL drain_fflags_second: got %h want 01", fflags); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || fflags !== 5'h01) begin n_fail++; $display("FAIL drain_empty: valid %b fflags %h want 0 01", out_valid, fflags); end
  endtask

  task automatic test_csr_merge();
    out_ready = 1'b0;
    drive(1'b1, 32'h40400000, 5'd5, F_NX);
    tick();
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1; csr_wr_en = 1'b1; csr_wr_data = F_NV;
    tick();
    n_checks++; if (fflags !== 5'h11) begin n_fail++; $display("FAIL csr_merge_commit: got %h want 11", fflags); end
    out_ready = 1'b0; csr_wr_data = 5'h00;
    tick();
    n_checks++; if (fflags !== 5'h00) begin n_fail++; $display("FAIL csr_write_clear: got %h want 00", fflags); end
    csr_wr_data = F_UF;
    tick();
    csr_wr_en = 1'b0;
    tick();
    n_checks++; if (fflags !== 5'h02) begin n_fail++; $display("FAIL csr_write_hold: got %h want 02", fflags); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'h41000000, 5'd6, F_NX);
    tick();
    drive(1'b1, 32'h41100000, 5'd7, F_UF);
    tick();
    drive(1'b0, '0, '0, '0);
    rst = 1'b1; out_ready = 1'b1; csr_wr_en = 1'b1; csr_wr_data = 5'h1F;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_asserted: got %b want 0", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: valid %b busy %b want 0 0", out_valid, busy); end
    n_checks++; if (fflags !== 5'h00) begin n_fail++; $display("FAIL rstmid_fflags: got %h want 00", fflags); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_empty: got %b want 0", in_ready); end
    rst = 1'b0; csr_wr_en = 1'b0; csr_wr_data = '0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_after: got %b want 1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || fflags !== 5'h00) begin n_fail++; $display("FAIL rstmid_stays_empty: valid %b fflags %h want 0 00", out_valid, fflags); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h40000000 + 32'(i), 5'(i), 5'h00);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready%0d: got %b want 1", i, in_ready); end
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'(i) || out_result !== 32'h40000000 + 32'(i)) begin
        n_fail++; $display("FAIL stream_out%0d: valid %b tag %0d result %h want 1 %0d %h", i, out_valid, out_tag, out_result, i, 32'h40000000 + 32'(i));
      end
    end
    drive(1'b0, '0, '0, '0);
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end: out_valid got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_csr_merge();
    test_reset_mid();
    test_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
